data_memory_ctrl: RTL

//  Parametrised byte-addressed data memory for the RV pipeline's MEM stage.

---
 rtl/data_memory_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressed load/store memory for the MEM stage.
// One request is outstanding at a time; each response is held until the consumer takes it.
module data_memory_ctrl #(
    parameter int    DATA_W       = 64,
    parameter int    DEPTH        = 64,
    parameter int    ADDR_W       = 64,
    parameter int    READ_LATENCY = 1,
    parameter bit    BIG_ENDIAN   = 1'b1,
    parameter string INIT_FILE    = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_fault
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [1:0]        cnt_reg, cnt_next;
    logic [DATA_W-1:0] rdata_reg;
    logic              fault_reg;

    logic [7:0]        mem [DEPTH];

    logic              accept;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        nbytes;
    logic [3:0]        align_mask;
    logic              fault;
    logic [IDX_W-1:0]  byte_addr [NB];
    logic [DATA_W-1:0] ld_field, ld_keep, ld_value;
    logic              sign_bit;
    logic              unused_addr;

    assign req_ready   = (state_reg == IDLE) & ~rst;
    assign accept      = req_valid & req_ready;
    assign idx         = req_addr[IDX_W-1:0];
    assign unused_addr = ^req_addr;
    assign nbytes      = 4'd1 << req_size;
    assign align_mask  = nbytes - 4'd1;
    assign fault       = ((4'(idx) & align_mask) != 4'd0) || (req_size == 2'b11 && DATA_W == 32);

    // Lane gi carries byte gi of the field (gi=0 is least significant).
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            if (BIG_ENDIAN) begin : g_be
                assign byte_addr[gi] = idx + IDX_W'(nbytes - 4'(gi) - 4'd1);
            end else begin : g_le
                assign byte_addr[gi] = idx + IDX_W'(gi);
            end
        end
    endgenerate

    always_comb begin
        ld_field = '0;
        ld_keep  = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(nbytes)) begin
                ld_field[8*i +: 8] = mem[byte_addr[i]];
                ld_keep[8*i +: 8]  = 8'hFF;
            end
        end
        case (req_size)
            2'b00:   sign_bit = ld_field[7];
            2'b01:   sign_bit = ld_field[15];
            2'b10:   sign_bit = ld_field[31];
            default: sign_bit = 1'b0;
        endcase
        ld_value = ld_field;
        if (sign_bit && !req_unsigned) begin
            ld_value = ld_field | ~ld_keep;
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    end

    // Memory has no reset: contents survive rst.
    always_ff @(posedge clk) begin
        if (accept && req_write && !fault) begin
            for (int i = 0; i < NB; i++) begin
                if (i < int'(nbytes)) mem[byte_addr[i]] <= req_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (req_write || READ_LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 2'(READ_LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 2'd0) state_next = RESP;
                else                 cnt_next   = cnt_reg - 2'd1;
            end
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Load data is captured at the accept edge and held through WAIT and RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 2'd0;
            rdata_reg <= '0;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                fault_reg <= fault;
                rdata_reg <= (req_write || fault) ? '0 : ld_value;
            end
        end
    end

    assign rsp_valid = (state_reg == RESP);
    assign rsp_rdata = rdata_reg;
    assign rsp_fault = fault_reg;

endmodule
